// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter.
//   state_t        : measurement FSM states
//   DIGITS_DEFAULT : default number of BCD decades
//   BCD_NINE       : highest legal value of one decade
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_LATCH = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam int DIGITS_DEFAULT = 8;

  localparam logic [3:0] BCD_NINE = 4'd9;

endpackage : freq_meter_pkg

// File: rtl/bcd_digit.sv
// One BCD decade of the window counter.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear, takes priority over counting
//   en         : global count enable (dropped at saturation)
//   carry_in   : increment request from the decade below
//   digit      : current decade value, always 0..9
//   carry_out  : this decade is rolling over 9 -> 0
module bcd_digit
  import freq_meter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       carry_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Carry does not depend on en, so the top carry can gate en without a loop.
  assign carry_out = carry_in && (digit_q == BCD_NINE);
  assign digit     = digit_q;

  always_comb begin
    // NOTE: default assignment first, so no path leaves digit_d unassigned and no latch is inferred.
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (en && carry_in) begin
      digit_d = (digit_q == BCD_NINE) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) digit_q <= '0;
    else       digit_q <= digit_d;
  end

endmodule : bcd_digit

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of sig_in while the 1 Hz
// gate is high and publishes the result as packed BCD.
//   clk      : 50 MHz system clock
//   reset    : asynchronous active-high reset
//   clk_1hz  : gate timebase, synchronous to clk
//   sig_in   : measured signal, asynchronous to clk
//   bcd_out  : last completed count, digit 0 in bits [3:0]
//   valid    : one-cycle pulse when bcd_out/overflow are updated
//   overflow : last window exceeded 10^DIGITS-1
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_1hz,
  input  logic                  sig_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  valid,
  output logic                  overflow
);

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                sync3_q, sync3_d;
  logic                gate_q, gate_d;
  logic                ovf_sticky_q, ovf_sticky_d;
  logic [4*DIGITS-1:0] bcd_out_q, bcd_out_d;
  logic                overflow_q, overflow_d;
  logic                valid_q, valid_d;

  logic                sig_rise;
  logic                gate_rise;
  logic                gate_fall;
  logic                inc;
  logic                cnt_en;
  logic                cnt_clr;
  logic [4*DIGITS-1:0] count;
  logic [DIGITS:0]     carry;

  assign sig_rise  = sync2_q && !sync3_q;
  assign gate_rise = clk_1hz && !gate_q;
  assign gate_fall = !clk_1hz && gate_q;

  // An edge coinciding with the gate closing belongs to no window.
  assign inc      = (state_q == ST_COUNT) && sig_rise && !gate_fall;
  assign cnt_clr  = (state_q == ST_CLEAR);
  assign carry[0] = inc;
  // Top carry means the counter is at all-9s: freeze every decade instead of wrapping.
  assign cnt_en   = !carry[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clr       (cnt_clr),
      .en        (cnt_en),
      .carry_in  (carry[i]),
      .digit     (count[4*i +: 4]),
      .carry_out (carry[i+1])
    );
  end

  always_comb begin
    sync1_d      = sig_in;
    sync2_d      = sync1_q;
    sync3_d      = sync2_q;
    gate_d       = clk_1hz;
    state_d      = state_q;
    bcd_out_d    = bcd_out_q;
    overflow_d   = overflow_q;
    valid_d      = 1'b0;
    ovf_sticky_d = cnt_clr ? 1'b0 : (ovf_sticky_q || carry[DIGITS]);

    unique case (state_q)
      ST_IDLE:  if (gate_rise) state_d = ST_COUNT;
      ST_COUNT: if (gate_fall) state_d = ST_LATCH;
      ST_LATCH: begin
        bcd_out_d  = count;
        overflow_d = ovf_sticky_q;
        valid_d    = 1'b1;
        state_d    = ST_CLEAR;
      end
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      gate_q       <= 1'b0;
      ovf_sticky_q <= 1'b0;
      bcd_out_q    <= '0;
      overflow_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      gate_q       <= gate_d;
      ovf_sticky_q <= ovf_sticky_d;
      bcd_out_q    <= bcd_out_d;
      overflow_q   <= overflow_d;
      valid_q      <= valid_d;
    end
  end

  assign bcd_out  = bcd_out_q;
  assign overflow = overflow_q;
  assign valid    = valid_q;

endmodule : freq_meter

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: an 8-decade and a 2-decade instance share all
// stimulus. Each gate window pushes its expected result to a queue; a
// monitor pops and compares whenever valid pulses.
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_1hz;
  logic        sig_in;
  logic [31:0] bcd8;
  logic        valid8;
  logic        ovf8;
  logic [7:0]  bcd2;
  logic        valid2;
  logic        ovf2;

  typedef struct packed {
    logic [31:0] bcd8;
    logic        ovf8;
    logic [7:0]  bcd2;
    logic        ovf2;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          errors    = 0;
  int          checks    = 0;
  int          valid_cnt = 0;
  logic [31:0] last_bcd8 = '0;

  always #10 clk = ~clk;

  freq_meter #(.DIGITS(8)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .clk_1hz  (clk_1hz),
    .sig_in   (sig_in),
    .bcd_out  (bcd8),
    .valid    (valid8),
    .overflow (ovf8)
  );

  freq_meter #(.DIGITS(2)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .clk_1hz  (clk_1hz),
    .sig_in   (sig_in),
    .bcd_out  (bcd2),
    .valid    (valid2),
    .overflow (ovf2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Saturating decimal-to-packed-BCD conversion.
  function automatic logic [31:0] to_bcd(input int n, input int digits);
    logic [31:0] r;
    int          lim;
    int          v;
    r   = '0;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    v = (n > lim - 1) ? lim - 1 : n;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic exp_t make_exp(input int n);
    exp_t        e;
    logic [31:0] b2;
    b2     = to_bcd(n, 2);
    e.bcd8 = to_bcd(n, 8);
    e.ovf8 = (n > 99999999);
    e.bcd2 = b2[7:0];
    e.ovf2 = (n > 99);
    return e;
  endfunction

  function automatic logic pulse_level(input int c, input int first, input int period, input int n_edges);
    if (c < first) return 1'b0;
    if ((c - first) / period >= n_edges) return 1'b0;
    return ((c - first) % period) < (period / 2);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Gate high for high_cyc cycles with sig_in pulses inside it. A rise
  // driven at cycle c is seen by the counter 2 edges later; the gate fall
  // is seen 1 edge after it is driven, so a rise at high_cyc-2 lands in
  // the gate_fall cycle and is dropped.
  task automatic run_window(input int high_cyc, input int first, input int period, input int n_edges);
    int   cnt;
    exp_t e;
    cnt = 0;
    for (int c = 0; c < high_cyc; c++) begin
      @(negedge clk);
      clk_1hz = 1'b1;
      sig_in  = pulse_level(c, first, period, n_edges);
      if (c >= first && (c - first) % period == 0 && (c - first) / period < n_edges && c <= high_cyc - 3)
        cnt++;
    end
    @(negedge clk);
    clk_1hz = 1'b0;
    sig_in  = 1'b0;
    e = make_exp(cnt);
    sb_q.push_back(e);
    last_bcd8 = e.bcd8;
    @(negedge clk);
    check("valid_early", {63'b0, valid8}, 64'd0);
    @(negedge clk);
    check("valid_2_after_fall", {63'b0, valid8}, 64'd1);
    @(negedge clk);
    check("valid_one_cycle", {63'b0, valid8}, 64'd0);
    idle(4);
  endtask

  // Scoreboard: compare on every valid pulse.
  always @(negedge clk) begin
    if (!reset && (valid8 || valid2)) begin
      valid_cnt++;
      check("valid_pair", {63'b0, valid2}, {63'b0, valid8});
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", {63'b0, valid8}, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("bcd8", {32'b0, bcd8}, {32'b0, mon_e.bcd8});
        check("ovf8", {63'b0, ovf8}, {63'b0, mon_e.ovf8});
        check("bcd2", {56'b0, bcd2}, {56'b0, mon_e.bcd2});
        check("ovf2", {63'b0, ovf2}, {63'b0, mon_e.ovf2});
      end
    end
  end

  initial begin
    int v_before;
    reset   = 1'b1;
    clk_1hz = 1'b0;
    sig_in  = 1'b0;
    #1;
    check("rst_bcd8", {32'b0, bcd8}, 64'd0);
    check("rst_valid", {63'b0, valid8}, 64'd0);
    check("rst_ovf2", {63'b0, ovf2}, 64'd0);
    idle(3);
    reset = 1'b0;
    idle(5);

    // 1000-cycle gate, period 10: 100 edges (8 digits) / saturated (2 digits).
    run_window(1000, 2, 10, 1000);
    idle(20);
    check("hold_after_latch", {32'b0, bcd8}, {32'b0, last_bcd8});

    // Quiet window.
    run_window(200, 0, 10, 0);

    // 150 edges, then a small window to show overflow clears.
    run_window(1600, 2, 10, 150);
    run_window(300, 3, 10, 5);

    // Edges while the gate is low are ignored.
    v_before = valid_cnt;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      sig_in = pulse_level(c, 0, 10, 20);
    end
    @(negedge clk);
    sig_in = 1'b0;
    idle(5);
    check("gate_low_no_valid", 64'(valid_cnt), 64'(v_before));
    check("gate_low_hold", {32'b0, bcd8}, {32'b0, last_bcd8});
    run_window(300, 3, 10, 6);

    // Last rise in the gate_fall cycle (excluded), then one cycle earlier (counted).
    run_window(50, 8, 10, 5);
    run_window(50, 7, 10, 5);

    // Reset mid-window after 40 edges.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      clk_1hz = 1'b1;
      sig_in  = pulse_level(c, 2, 10, 40);
    end
    @(negedge clk);
    v_before = valid_cnt;
    reset    = 1'b1;
    clk_1hz  = 1'b0;
    sig_in   = 1'b0;
    #1;
    check("midrst_bcd8", {32'b0, bcd8}, 64'd0);
    check("midrst_bcd2", {56'b0, bcd2}, 64'd0);
    check("midrst_ovf8", {63'b0, ovf8}, 64'd0);
    check("midrst_valid", {63'b0, valid8}, 64'd0);
    idle(3);
    reset = 1'b0;
    idle(30);
    check("midrst_no_valid", 64'(valid_cnt), 64'(v_before));
    run_window(300, 3, 10, 7);

    idle(5);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_freq_meter
